fp_to_twos: RTL and testbench



---
 rtl/fp_to_twos.sv | 112 +++++++++++
 tb/tb_fp_to_twos.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fp_to_twos.sv
// fp_to_twos: sequential decoder from the 1/3/4 floating-point sample code
// (value = (-1)^S * F * 2^E) to a 12-bit two's-complement word.
// One code is accepted per transaction through an in_valid/in_ready handshake
// and the result is returned through an out_valid/out_ready handshake.
// Optional build macro: FP_TO_TWOS_BARREL_EN -- when defined, the magnitude is
// shifted into place on the accept edge, so SHIFT always lasts one cycle.
// When it is undefined, the magnitude is shifted one bit per cycle and
// latency is E+1 cycles.
module fp_to_twos (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        S,
  input  logic [2:0]  E,
  input  logic [3:0]  F,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] D
);

  localparam int unsigned EXP_W = 3;
  localparam int unsigned SIG_W = 4;
  localparam int unsigned OUT_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   mag_q, mag_d;
  logic [EXP_W-1:0]   cnt_q, cnt_d;
  logic               sgn_q, sgn_d;
  logic [OUT_W-1:0]   d_q, d_d;
  logic               out_valid_q, out_valid_d;

  // Ready is decoded from state alone, so it never depends on out_ready.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign D         = d_q;

  // State and datapath registers; reset discards any in-flight value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      cnt_q       <= '0;
      sgn_q       <= 1'b0;
      d_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      sgn_q       <= sgn_d;
      d_q         <= d_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath update: accept, shift, negate, hand off.
  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    cnt_d       = cnt_q;
    sgn_d       = sgn_q;
    d_d         = d_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef FP_TO_TWOS_BARREL_EN
          mag_d = OUT_W'(F) << E;
          cnt_d = '0;
`else
          mag_d = {(OUT_W - SIG_W)'(0), F};
          cnt_d = E;
`endif
          sgn_d   = S;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt_q != '0) begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q - EXP_W'(1);
        end else begin
          // Max magnitude 0x780 fits in 11 bits; negating zero yields zero.
          d_d         = sgn_q ? (~mag_q + OUT_W'(1)) : mag_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fp_to_twos.sv
// Directed and exhaustive bench for fp_to_twos. Inputs change on the falling
// edge; outputs are sampled 1 time unit after the rising edge.
module tb_fp_to_twos;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] D;

  int n_tests;
  int n_fail;

  fp_to_twos dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S         (S),
    .E         (E),
    .F         (F),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [2:0]  e;
    logic [3:0]  f;
    logic [11:0] exp_d;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic int exp_latency(input logic [2:0] e);
`ifdef FP_TO_TWOS_BARREL_EN
    return 1;
`else
    return int'(e) + 1;
`endif
  endfunction

  // Offer one code, measure edges until out_valid, then let it drain.
  task automatic run_one(input logic s, input logic [2:0] e, input logic [3:0] f,
                         input logic [11:0] exp_d, input bit check_lat,
                         input string tag);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready idle"}, int'(in_ready), 1);
    S = s; E = e; F = f; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    S = ~s; E = ~e; F = ~f;
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk({tag, " in_ready busy"}, int'(in_ready), 0);
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " out_valid"}, int'(out_valid), 1);
    chk({tag, " D"}, int'(D), int'(exp_d));
    if (check_lat) chk({tag, " latency"}, lat, exp_latency(e));
    chk({tag, " in_ready done"}, int'(in_ready), 0);
    @(posedge clk);
    #1;
    chk({tag, " back to idle"}, int'(in_ready), 1);
    chk({tag, " out_valid drop"}, int'(out_valid), 0);
  endtask

  initial begin
    logic [11:0] m;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    S = 1'b0; E = 3'd0; F = 4'd0;

    vecs[0] = '{1'b0, 3'd0, 4'b0101, 12'h005};
    vecs[1] = '{1'b0, 3'd7, 4'b1111, 12'h780};
    vecs[2] = '{1'b1, 3'd3, 4'b1000, 12'hFC0};
    vecs[3] = '{1'b1, 3'd5, 4'b0000, 12'h000};
    vecs[4] = '{1'b1, 3'd0, 4'b0001, 12'hFFF};
    vecs[5] = '{1'b0, 3'd1, 4'b0011, 12'h006};
    vecs[6] = '{1'b1, 3'd7, 4'b1111, 12'h880};

    // Reset state
    #12;
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset D", int'(D), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset in_ready", int'(in_ready), 1);

    // Directed table
    for (int i = 0; i < 7; i++)
      run_one(vecs[i].s, vecs[i].e, vecs[i].f, vecs[i].exp_d, 1'b1, $sformatf("vec%0d", i));

    // Backpressure: result held while out_ready low, new input ignored
    out_ready = 1'b0;
    @(negedge clk);
    S = 1'b1; E = 3'd0; F = 4'b0001; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 0; k < 20 && !out_valid; k++) begin
      @(posedge clk);
      #1;
    end
    chk("bp out_valid rise", int'(out_valid), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      S = 1'b0; E = 3'd2; F = 4'd7; in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("bp D hold", int'(D), 12'hFFF);
      chk("bp out_valid hold", int'(out_valid), 1);
      chk("bp in_ready low", int'(in_ready), 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release out_valid", int'(out_valid), 0);
    chk("bp release in_ready", int'(in_ready), 1);
    chk("bp D kept", int'(D), 12'hFFF);

    // Reset mid-operation
    @(negedge clk);
    S = 1'b0; E = 3'd6; F = 4'd1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", int'(out_valid), 0);
    chk("midrst D", int'(D), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_one(1'b0, 3'd1, 4'b0011, 12'h006, 1'b1, "after reset");

    // Exhaustive sweep against the arithmetic value
    for (int c = 0; c < 256; c++) begin
      logic [7:0] code;
      code = 8'(c);
      m = 12'(code[3:0]) << code[6:4];
      if (code[7]) m = 12'(0) - m;
      run_one(code[7], code[6:4], code[3:0], m, 1'b1, $sformatf("sweep%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
